// File: rtl/valu_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a shared vector ALU.
// Latches the winner's operands, drives the ALU until done or watchdog expiry, then returns a one-cycle response.
module valu_issue_arbiter #(
    parameter int VLEN    = 512,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [15:0]       req_instr,
    input  logic [2*VLEN-1:0] req_opA,
    input  logic [2*VLEN-1:0] req_opB,
    input  logic [2*VLEN-1:0] req_opC,
    input  logic [63:0]       req_sew,
    input  logic [7:0]        req_vap,
    output logic [1:0]        rsp_valid,
    output logic [VLEN-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        alu_instr,
    output logic              alu_enb,
    input  logic              alu_done,
    output logic [VLEN-1:0]   alu_opA,
    output logic [VLEN-1:0]   alu_opB,
    output logic [VLEN-1:0]   alu_opC,
    input  logic [VLEN-1:0]   alu_out,
    output logic [31:0]       alu_sew,
    output logic [3:0]        alu_vap,
    output logic [31:0]       alu_vlmax
);

    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_grant;
    logic [WDW-1:0]   r_wdog;

    logic             w_any;
    logic             w_win;
    logic [31:0]      w_sew;
    logic             w_legal;
    logic [31:0]      w_vlmax;

    always_comb begin
        w_any   = |req_valid;
        // With both valid, the requester that did not win last time goes first.
        w_win   = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
        w_sew   = w_win ? req_sew[63:32] : req_sew[31:0];
        w_legal = 1'b1;
        w_vlmax = 32'd0;
        case (w_sew)
            32'd8:   w_vlmax = 32'(VLEN >> 3);
            32'd16:  w_vlmax = 32'(VLEN >> 4);
            32'd32:  w_vlmax = 32'(VLEN >> 5);
            32'd64:  w_vlmax = 32'(VLEN >> 6);
            default: w_legal = 1'b0;
        endcase
        req_ready = 2'b00;
        if (!reset && r_state == S_IDLE && w_any)
            req_ready = w_win ? 2'b10 : 2'b01;
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_wdog       <= '0;
            rsp_valid    <= 2'b00;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            alu_instr    <= '0;
            alu_enb      <= 1'b0;
            alu_opA      <= '0;
            alu_opB      <= '0;
            alu_opC      <= '0;
            alu_sew      <= '0;
            alu_vap      <= '0;
            alu_vlmax    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    rsp_valid <= 2'b00;
                    if (w_any) begin
                        r_grant      <= w_win;
                        r_last_grant <= w_win;
                        r_wdog       <= '0;
                        alu_instr    <= w_win ? req_instr[15:8] : req_instr[7:0];
                        alu_opA      <= w_win ? req_opA[2*VLEN-1:VLEN] : req_opA[VLEN-1:0];
                        alu_opB      <= w_win ? req_opB[2*VLEN-1:VLEN] : req_opB[VLEN-1:0];
                        alu_opC      <= w_win ? req_opC[2*VLEN-1:VLEN] : req_opC[VLEN-1:0];
                        alu_sew      <= w_sew;
                        alu_vap      <= w_win ? req_vap[7:4] : req_vap[3:0];
                        alu_vlmax    <= w_vlmax;
                        if (w_legal) begin
                            r_state <= S_RUN;
                            alu_enb <= 1'b1;
                        end else begin
                            // Illegal SEW never reaches the ALU; answer with an error next cycle.
                            r_state   <= S_RESP;
                            rsp_valid <= {w_win, ~w_win};
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (alu_done) begin
                        r_state   <= S_RESP;
                        alu_enb   <= 1'b0;
                        rsp_valid <= {r_grant, ~r_grant};
                        rsp_data  <= alu_out;
                        rsp_err   <= 1'b0;
                    end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                        r_state   <= S_RESP;
                        alu_enb   <= 1'b0;
                        rsp_valid <= {r_grant, ~r_grant};
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 2'b00;
                    r_wdog    <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    alu_enb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/valu_issue_arbiter.md
Name: valu_issue_arbiter

Overview:
- Sequences and shares one vector_alu between two issue requesters (index 0, 1).
- Arbitrates round-robin and latches the winner's instruction, operands, SEW and vap.
- Holds the ALU enable until alu_done, then returns the result to the granted requester.
- Checks SEW legality, derives vlmax, and aborts hung operations with a watchdog.

Parameters:
VLEN, 512, vector operand/result width in bits
TIMEOUT, 64, max cycles alu_enb may stay high without alu_done before abort (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
req_valid  input  2  request valid per requester
req_ready  output  2  one-hot accept pulse; handshake completes when valid&ready
req_instr  input  16  instruction per requester, requester i at [i*8 +: 8]
req_opA  input  2*VLEN  operand A per requester, [i*VLEN +: VLEN]
req_opB  input  2*VLEN  operand B per requester
req_opC  input  2*VLEN  operand C (accumulator) per requester
req_sew  input  64  element width per requester, [i*32 +: 32]
req_vap  input  8  vap per requester, [i*4 +: 4]
rsp_valid  output  2  one-hot, one-cycle response pulse to requester owning the op
rsp_data  output  VLEN  result, valid while rsp_valid!=0
rsp_err  output  1  qualifies rsp_valid: 1 = illegal SEW or timeout
busy  output  1  high in every state except IDLE
alu_instr  output  8  instruction to ALU
alu_enb  output  1  ALU enable
alu_done  input  1  ALU completion
alu_opA, alu_opB, alu_opC  output  VLEN each  operands to ALU
alu_out  input  VLEN  ALU result
alu_sew  output  32  SEW to ALU
alu_vap  output  4  vap to ALU
alu_vlmax  output  32  VLEN/SEW

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1 so requester 0 wins first; watchdog=0.
- Reset mid-operation drops the in-flight op with no response. The ALU sees alu_enb=0 on the next cycle.
- IDLE: if any req_valid, pick a winner.
  - Only one valid: that one wins.
  - Both valid: the requester != last_grant wins.
  - Drive req_ready[winner]=1 for that cycle only (combinational from IDLE and valids).
  - Latch instr, opA/B/C, SEW and vap into ALU-facing registers. Set last_grant=winner.
  - Next state is RUN if SEW is legal, otherwise RESP with err=1.
- SEW legal set: {8,16,32,64}.
  - alu_vlmax = VLEN>>log2(SEW), registered with the operands (VLEN=512: 64/32/16/8).
  - Illegal SEW: alu_vlmax=0 and alu_enb never asserts.
- RUN: alu_enb=1; ALU-facing outputs held stable; watchdog increments each cycle.
  - alu_done=1: capture alu_out into rsp_data, err=0, go to RESP.
  - Else if watchdog==TIMEOUT-1: rsp_data=0, err=1, go to RESP.
  - alu_done and timeout in the same cycle: done wins.
- RESP: alu_enb=0; rsp_valid[granted]=1 for exactly one cycle; rsp_err per latched flag; watchdog cleared; go to IDLE.
  - No response backpressure; requesters must sample in the pulse cycle.
- Latency: accept at cycle T; alu_enb high T+1 through the cycle done is sampled (T+k). rsp_valid at T+k+1. Earliest next accept at T+k+2.
- alu_done sampled only in RUN; ignored in IDLE and RESP.
- req_valid may drop without handshake; no request is queued.
- rsp_data and rsp_err hold their last value after the pulse until the next RESP.

Test Plan:
- Single op: req0 instr=0x03 (vmacc), opB={32'h87654321,480'd0}, opA={128'h1111...1111,384'd0}, opC=0, SEW=16, vap=3; stub raises alu_done 4 cycles after alu_enb with alu_out=X.
  - req_ready=01 at T; alu_enb high T+1..T+4; alu_vlmax=32, alu_vap=3, alu_instr=0x03.
  - rsp_valid=01 at T+5, rsp_data=X, rsp_err=0.
- Contention: both valid from reset (req0 instr 0x00, req1 instr 0x01) and held.
  - Grants alternate 0,1,0,1; each rsp_valid one-hot matches its grant.
  - alu_instr alternates 0x00/0x01.
- Illegal SEW: req1 SEW=12 → ready pulse, alu_enb stays 0, next cycle rsp_valid=10, rsp_err=1, alu_vlmax=0.
- Timeout: TIMEOUT=8, stub never asserts done → alu_enb high exactly 8 cycles, then rsp_valid with rsp_err=1 and rsp_data=0; busy returns to 0.
- Done on the last watchdog cycle (cycle 8, TIMEOUT=8) → rsp_err=0, rsp_data=alu_out.
- Reset asserted during RUN → next cycle alu_enb=0, busy=0, no rsp_valid. After release, req1 valid alone is granted first.
